mem_load_arbiter: RTL and testbench

MEM_LOAD_ARBITER -- requirements
Module: mem_load_arbiter

---
 rtl/mem_load_arbiter_pkg.sv | 18 +
 rtl/mem_load_arbiter_if.sv | 31 +++
 rtl/mem_load_arbiter_load_counter.sv | 46 ++++
 rtl/mem_load_arbiter.sv | 131 +++++++++++++
 tb/tb_mem_load_arbiter.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_load_arbiter_pkg.sv
// Shared constants for the memory load arbiter: FSM encoding, store code and word stride.
package mem_load_arbiter_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE    = 2'd0;
  localparam state_t ST_LOAD    = 2'd1;
  localparam state_t ST_RELEASE = 2'd2;
  localparam state_t ST_RUN     = 2'd3;

  localparam logic [2:0]  STORE_WORD  = 3'b010;
  localparam int unsigned WORD_STRIDE = 4;

  function automatic logic len_ok(input int unsigned len, input int unsigned max_words);
    return len <= max_words;
  endfunction

endpackage

// File: rtl/mem_load_arbiter_if.sv
// Bus bundle between host load stream, CPU write port and data memory.
interface mem_load_arbiter_if #(
  parameter int DW = 32,
  parameter int AW = 32
);

  logic          ld_valid;
  logic [DW-1:0] ld_data;
  logic          ld_ready;

  logic          cpu_we;
  logic [AW-1:0] cpu_adr;
  logic [DW-1:0] cpu_wdata;
  logic [2:0]    cpu_store;

  logic          mem_we;
  logic [AW-1:0] mem_adr;
  logic [DW-1:0] mem_wdata;
  logic [2:0]    mem_store;

  modport master (
    output ld_valid, ld_data, cpu_we, cpu_adr, cpu_wdata, cpu_store,
    input  ld_ready, mem_we, mem_adr, mem_wdata, mem_store
  );

  modport slave (
    input  ld_valid, ld_data, cpu_we, cpu_adr, cpu_wdata, cpu_store,
    output ld_ready, mem_we, mem_adr, mem_wdata, mem_store
  );

endinterface

// File: rtl/mem_load_arbiter_load_counter.sv
// Word index / remaining-count pair for a load; idx counts up while remaining counts down.
module load_counter #(
  parameter int CW = 7
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  input  logic          dec,
  output logic [CW-1:0] idx,
  output logic          last
);

  logic [CW-1:0] idx_q, idx_d;
  logic [CW-1:0] remaining_q, remaining_d;

  always_comb begin
    idx_d       = idx_q;
    remaining_d = remaining_q;
    if (load) begin
      idx_d       = '0;
      remaining_d = load_val;
    end else if (dec) begin
      idx_d       = idx_q + 1'b1;
      remaining_d = remaining_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx_q       <= '0;
      remaining_q <= '0;
    end else if (clr) begin
      idx_q       <= '0;
      remaining_q <= '0;
    end else begin
      idx_q       <= idx_d;
      remaining_q <= remaining_d;
    end
  end

  assign idx  = idx_q;
  assign last = (remaining_q == CW'(1));

endmodule

// File: rtl/mem_load_arbiter.sv
// Holds the CPU in reset while a host streams words into data memory, then hands the port to the CPU.
module mem_load_arbiter
  import mem_load_arbiter_pkg::*;
#(
  parameter int          DW        = 32,
  parameter int          AW        = 32,
  parameter int unsigned MAX_WORDS = 64,
  parameter logic [AW-1:0] BASE_ADDR = '0
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic [$clog2(MAX_WORDS+1)-1:0] len,
  input  logic                           abort,
  mem_load_arbiter_if.slave              bus,
  output logic                           cpu_hold,
  output logic                           busy,
  output logic                           done,
  output logic                           err
);

  localparam int CW = $clog2(MAX_WORDS + 1);

  logic [1:0]    sync_q, sync_d;
  logic          rst_done;
  state_t        state_q, state_d;
  logic          err_q, err_d;
  logic          cnt_load, cnt_dec, cnt_last;
  logic [CW-1:0] idx;
  logic          xfer;
  logic          len_valid;

  // Reset asserts asynchronously but releases through two flops, so the FSM is
  // held in IDLE until the second edge after the pin goes high.
  always_comb sync_d = {sync_q[0], 1'b1};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) sync_q <= '0;
    else        sync_q <= sync_d;
  end

  assign rst_done = sync_q[1];

  load_counter #(.CW(CW)) u_cnt (
    .clk      (clk),
    .reset    (reset),
    .clr      (!rst_done),
    .load     (cnt_load),
    .load_val (len),
    .dec      (cnt_dec),
    .idx      (idx),
    .last     (cnt_last)
  );

  assign len_valid = len_ok(32'(len), MAX_WORDS);
  // Abort wins over a transfer presented in the same cycle.
  assign xfer      = (state_q == ST_LOAD) && bus.ld_valid && !abort;

  always_comb begin
    state_d  = state_q;
    err_d    = err_q;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    case (state_q)
      ST_IDLE, ST_RUN: begin
        if (start) begin
          if (!len_valid) begin
            err_d = 1'b1;
          end else begin
            err_d = 1'b0;
            if (len == '0) begin
              state_d = ST_RELEASE;
            end else begin
              cnt_load = 1'b1;
              state_d  = ST_LOAD;
            end
          end
        end
      end
      ST_LOAD: begin
        if (abort) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else if (xfer) begin
          cnt_dec = 1'b1;
          if (cnt_last) state_d = ST_RELEASE;
        end
      end
      ST_RELEASE: state_d = ST_RUN;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      err_q   <= 1'b0;
    end else if (!rst_done) begin
      state_q <= ST_IDLE;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    bus.ld_ready  = (state_q == ST_LOAD);
    bus.mem_we    = 1'b0;
    bus.mem_adr   = '0;
    bus.mem_wdata = '0;
    bus.mem_store = '0;
    if (xfer) begin
      bus.mem_we    = 1'b1;
      bus.mem_adr   = BASE_ADDR + AW'(idx) * AW'(WORD_STRIDE);
      bus.mem_wdata = bus.ld_data;
      bus.mem_store = STORE_WORD;
    end else if (state_q == ST_RUN) begin
      bus.mem_we    = bus.cpu_we;
      bus.mem_adr   = bus.cpu_adr;
      bus.mem_wdata = bus.cpu_wdata;
      bus.mem_store = bus.cpu_store;
    end
  end

  assign cpu_hold = (state_q != ST_RUN);
  assign busy     = (state_q == ST_LOAD) || (state_q == ST_RELEASE);
  assign done     = (state_q == ST_RELEASE);
  assign err      = err_q;

endmodule

// File: tb/tb_mem_load_arbiter.sv
// Directed bench for mem_load_arbiter with immediate-assertion checks at each step.
module tb_mem_load_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       abort;
  logic [6:0] len;
  logic       busy, done, err, cpu_hold;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mem_load_arbiter_if #(.DW(32), .AW(32)) bus ();

  mem_load_arbiter #(
    .DW        (32),
    .AW        (32),
    .MAX_WORDS (64),
    .BASE_ADDR (32'h0)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .len      (len),
    .abort    (abort),
    .bus      (bus),
    .cpu_hold (cpu_hold),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset         = 1'b0;
    start         = 1'b0;
    abort         = 1'b0;
    len           = '0;
    bus.ld_valid  = 1'b0;
    bus.ld_data   = '0;
    bus.cpu_we    = 1'b1;
    bus.cpu_adr   = 32'h40;
    bus.cpu_wdata = 32'h55;
    bus.cpu_store = 3'b010;

    // reset state, CPU writes ignored
    #2;
    chk("rst_hold",   cpu_hold,      1);
    chk("rst_ready",  bus.ld_ready,  0);
    chk("rst_we",     bus.mem_we,    0);
    chk("rst_busy",   busy,          0);
    chk("rst_done",   done,          0);
    chk("rst_err",    err,           0);
    chk("rst_adr",    bus.mem_adr,   0);
    chk("rst_wdata",  bus.mem_wdata, 0);
    chk("rst_store",  bus.mem_store, 0);
    bus.cpu_we = 1'b0;
    step();
    step();

    // synchronised release: start held across the first two edges is not taken
    reset = 1'b1;
    start = 1'b1;
    len   = 7'd1;
    step();
    chk("sync_e1_ready", bus.ld_ready, 0);
    step();
    chk("sync_e2_ready", bus.ld_ready, 0);
    start = 1'b0;
    step();

    // over-long length in IDLE
    start = 1'b1;
    len   = 7'd65;
    step();
    start = 1'b0;
    #1;
    chk("big_err",   err,          1);
    chk("big_ready", bus.ld_ready, 0);
    chk("big_hold",  cpu_hold,     1);
    chk("big_busy",  busy,         0);

    // len=3 back-to-back load
    start = 1'b1;
    len   = 7'd3;
    step();
    start        = 1'b0;
    bus.ld_valid = 1'b1;
    bus.ld_data  = 32'hA;
    #1;
    chk("l3_err_clr", err,           0);
    chk("l3_ready",   bus.ld_ready,  1);
    chk("l3_busy",    busy,          1);
    chk("l3_hold",    cpu_hold,      1);
    chk("l3_we0",     bus.mem_we,    1);
    chk("l3_adr0",    bus.mem_adr,   32'h0);
    chk("l3_dat0",    bus.mem_wdata, 32'hA);
    chk("l3_st0",     bus.mem_store, 3'b010);
    step();
    bus.ld_data = 32'hB;
    #1;
    chk("l3_we1",  bus.mem_we,    1);
    chk("l3_adr1", bus.mem_adr,   32'h4);
    chk("l3_dat1", bus.mem_wdata, 32'hB);
    step();
    bus.ld_data = 32'hC;
    #1;
    chk("l3_we2",  bus.mem_we,    1);
    chk("l3_adr2", bus.mem_adr,   32'h8);
    chk("l3_dat2", bus.mem_wdata, 32'hC);
    step();
    bus.ld_valid = 1'b0;
    #1;
    chk("rel_done",  done,         1);
    chk("rel_hold",  cpu_hold,     1);
    chk("rel_we",    bus.mem_we,   0);
    chk("rel_ready", bus.ld_ready, 0);
    step();
    chk("run_done", done,     0);
    chk("run_hold", cpu_hold, 0);
    chk("run_busy", busy,     0);

    // CPU pass-through in RUN, then a new load blocks it
    bus.cpu_we    = 1'b1;
    bus.cpu_adr   = 32'h40;
    bus.cpu_wdata = 32'h55;
    bus.cpu_store = 3'b010;
    #1;
    chk("cpu_we",    bus.mem_we,    1);
    chk("cpu_adr",   bus.mem_adr,   32'h40);
    chk("cpu_wdata", bus.mem_wdata, 32'h55);
    chk("cpu_store", bus.mem_store, 3'b010);
    start = 1'b1;
    len   = 7'd1;
    step();
    start = 1'b0;
    #1;
    chk("reld_hold",  cpu_hold,     1);
    chk("reld_block", bus.mem_we,   0);
    chk("reld_ready", bus.ld_ready, 1);
    bus.ld_valid = 1'b1;
    bus.ld_data  = 32'h77;
    #1;
    chk("reld_we",  bus.mem_we,    1);
    chk("reld_adr", bus.mem_adr,   32'h0);
    chk("reld_dat", bus.mem_wdata, 32'h77);
    step();
    bus.ld_valid = 1'b0;
    bus.cpu_we   = 1'b0;
    #1;
    chk("reld_done", done, 1);
    step();

    // gapped valid: 1,0,0,1
    start = 1'b1;
    len   = 7'd2;
    step();
    start        = 1'b0;
    bus.ld_valid = 1'b1;
    bus.ld_data  = 32'h11;
    #1;
    chk("gap_we0",  bus.mem_we,  1);
    chk("gap_adr0", bus.mem_adr, 32'h0);
    step();
    bus.ld_valid = 1'b0;
    #1;
    chk("gap_idle1", bus.mem_we, 0);
    chk("gap_busy",  busy,       1);
    step();
    chk("gap_idle2", bus.mem_we, 0);
    step();
    bus.ld_valid = 1'b1;
    bus.ld_data  = 32'h22;
    #1;
    chk("gap_we1",  bus.mem_we,    1);
    chk("gap_adr1", bus.mem_adr,   32'h4);
    chk("gap_dat1", bus.mem_wdata, 32'h22);
    step();
    bus.ld_valid = 1'b0;
    #1;
    chk("gap_done", done, 1);
    step();

    // invalid length in RUN keeps the CPU running
    start = 1'b1;
    len   = 7'd65;
    step();
    start = 1'b0;
    #1;
    chk("runbig_err",  err,      1);
    chk("runbig_hold", cpu_hold, 0);
    chk("runbig_busy", busy,     0);

    // abort after 1 of 4 words, with a transfer offered
    start = 1'b1;
    len   = 7'd4;
    step();
    start        = 1'b0;
    bus.ld_valid = 1'b1;
    bus.ld_data  = 32'h1;
    #1;
    chk("ab_err_clr", err,        0);
    chk("ab_we0",     bus.mem_we, 1);
    step();
    abort       = 1'b1;
    bus.ld_data = 32'h2;
    #1;
    chk("ab_nowrite", bus.mem_we, 0);
    step();
    abort        = 1'b0;
    bus.ld_valid = 1'b0;
    #1;
    chk("ab_err",   err,          1);
    chk("ab_busy",  busy,         0);
    chk("ab_hold",  cpu_hold,     1);
    chk("ab_ready", bus.ld_ready, 0);

    // abort in IDLE is ignored; the start is still taken
    abort = 1'b1;
    start = 1'b1;
    len   = 7'd3;
    step();
    abort = 1'b0;
    start = 1'b0;
    #1;
    chk("idleab_ready", bus.ld_ready, 1);
    chk("idleab_err",   err,          0);

    // reset in the cycle of the 2nd write
    bus.ld_valid = 1'b1;
    bus.ld_data  = 32'hA1;
    #1;
    chk("mid_we0", bus.mem_we, 1);
    step();
    bus.ld_data = 32'hA2;
    #1;
    chk("mid_we1",  bus.mem_we,  1);
    chk("mid_adr1", bus.mem_adr, 32'h4);
    reset = 1'b0;
    #1;
    chk("mid_rst_we",    bus.mem_we,    0);
    chk("mid_rst_idx",   dut.idx,       0);
    chk("mid_rst_busy",  busy,          0);
    chk("mid_rst_hold",  cpu_hold,      1);
    chk("mid_rst_ready", bus.ld_ready,  0);
    chk("mid_rst_adr",   bus.mem_adr,   0);
    chk("mid_rst_wdata", bus.mem_wdata, 0);
    bus.ld_valid = 1'b0;
    step();
    step();
    reset = 1'b1;
    repeat (3) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
